// File: rtl/router_out_fifo_if.sv
// router_out_fifo_if: write-side and destination-side signals
// of one router output buffer.
interface router_out_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              lfd_in;
  logic              write_en;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              read_en;
  logic              pkt_active;
  logic              soft_reset;

  modport master (
    output data_in, lfd_in, write_en, read_en,
    input  full, empty, data_out, valid_out,
    input  pkt_active, soft_reset
  );

  modport slave (
    input  data_in, lfd_in, write_en, read_en,
    output full, empty, data_out, valid_out,
    output pkt_active, soft_reset
  );
endinterface

// File: rtl/router_out_fifo.sv
// router_out_fifo: per-destination byte buffer with packet
// tracking and an unread-data timeout that flushes itself.
module router_out_fifo #(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30
) (
  input logic               clk,
  input logic               rst,
  router_out_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = DATA_W + 1;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [6:0]        pkt_q, pkt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              srst_q, srst_d;

  logic          full, empty;
  logic          wr_ok, rd_ok;
  logic          stall, flush;
  logic [EW-1:0] rd_ent;

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign stall  = !empty && !bus.read_en;
  assign flush  = stall && (tcnt_q == TW'(TIMEOUT - 1));
  assign wr_ok  = bus.write_en && !full && !flush;
  assign rd_ok  = bus.read_en && !empty;
  assign rd_ent = mem_q[rptr_q];

  // Next-state for pointers, occupancy, packet and timeout.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    pkt_d  = pkt_q;
    tcnt_d = '0;
    srst_d = 1'b0;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      dout_d = '0;
      pkt_d  = '0;
      srst_d = 1'b1;
    end else begin
      if (stall) begin
        tcnt_d = tcnt_q + 1'b1;
      end
      if (wr_ok) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_ok) begin
        rptr_d = rptr_q + 1'b1;
        dout_d = rd_ent[DATA_W-1:0];
        if (rd_ent[DATA_W]) begin
          pkt_d = 7'(rd_ent[DATA_W-1:2]) + 7'd1;
        end else if (pkt_q != '0) begin
          pkt_d = pkt_q - 7'd1;
        end
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Entry storage: header marker above the data byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (wr_ok) begin
      mem_q[wptr_q] <= {bus.lfd_in, bus.data_in};
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      pkt_q  <= '0;
      tcnt_q <= '0;
      srst_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      pkt_q  <= pkt_d;
      tcnt_q <= tcnt_d;
      srst_q <= srst_d;
    end
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.valid_out  = !empty;
  assign bus.data_out   = dout_q;
  assign bus.pkt_active = (pkt_q != '0);
  assign bus.soft_reset = srst_q;
endmodule

// File: tb/tb_router_out_fifo.sv
// tb_router_out_fifo: directed stimulus against a queue model
// of the router output buffer.
module tb_router_out_fifo;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_out_fifo_if #(.DATA_W(8)) bus ();

  router_out_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (8),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [8:0] mq [$];
  logic [7:0] m_dout = 8'h00;
  int         m_pkt  = 0;
  int         m_idle = 0;
  bit         m_srst = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: a queue of entries plus packet/idle counters.
  always @(posedge clk) begin : model
    logic [8:0] e;
    bit v, f;
    if (rst) begin
      mq.delete();
      m_dout = 8'h00;
      m_pkt  = 0;
      m_idle = 0;
      m_srst = 1'b0;
    end else begin
      v = (mq.size() != 0);
      f = (mq.size() == DEPTH);
      if (v && !bus.read_en && m_idle == TIMEOUT - 1) begin
        mq.delete();
        m_dout = 8'h00;
        m_pkt  = 0;
        m_idle = 0;
        m_srst = 1'b1;
      end else begin
        m_srst = 1'b0;
        m_idle = (v && !bus.read_en) ? m_idle + 1 : 0;
        if (bus.read_en && v) begin
          e = mq.pop_front();
          m_dout = e[7:0];
          if (e[8]) m_pkt = int'(e[7:2]) + 1;
          else if (m_pkt > 0) m_pkt--;
        end
        if (bus.write_en && !f)
          mq.push_back({bus.lfd_in, bus.data_in});
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_full", bus.full, mq.size() == DEPTH);
      chk("m_empty", bus.empty, mq.size() == 0);
      chk("m_valid", bus.valid_out, mq.size() != 0);
      chk("m_data", bus.data_out, m_dout);
      chk("m_pkt", bus.pkt_active, m_pkt != 0);
      chk("m_srst", bus.soft_reset, m_srst);
    end
  end

  task automatic wr(input logic [7:0] d, input logic l);
    bus.data_in  = d;
    bus.lfd_in   = l;
    bus.write_en = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.lfd_in   = 1'b0;
  endtask

  logic [7:0] pk [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h2E};

  initial begin
    bus.data_in  = 8'h00;
    bus.lfd_in   = 1'b0;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_full", bus.full, 0);

    // packet round trip
    for (int i = 0; i < 5; i++) wr(pk[i], i == 0);
    bus.read_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rt_data", bus.data_out, pk[i]);
      chk("rt_pkt", bus.pkt_active, i < 4);
    end
    bus.read_en = 1'b0;
    chk("rt_empty", bus.empty, 1);

    // zero-length header
    wr(8'h03, 1'b1);
    wr(8'h5A, 1'b0);
    bus.read_en = 1'b1;
    @(negedge clk);
    chk("len0_hdr", bus.pkt_active, 1);
    @(negedge clk);
    bus.read_en = 1'b0;
    chk("len0_par", bus.data_out, 8'h5A);
    chk("len0_done", bus.pkt_active, 0);

    // full boundary and wrap
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
    chk("full_16", bus.full, 1);
    wr(8'hFF, 1'b0);
    chk("full_drop", bus.full, 1);
    bus.read_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("wrap_data", bus.data_out, i);
    end
    bus.read_en = 1'b0;
    chk("wrap_empty", bus.empty, 1);

    // simultaneous read/write while full
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
    bus.data_in  = 8'hAA;
    bus.write_en = 1'b1;
    bus.read_en  = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0;
    chk("simf_pop", bus.data_out, 0);
    chk("simf_full", bus.full, 0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("simf_drain", bus.data_out, i);
    end
    bus.read_en = 1'b0;
    chk("simf_cnt15", bus.empty, 1);

    // simultaneous read/write while half full
    for (int i = 0; i < 8; i++) wr(8'(8'h40 + i), 1'b0);
    bus.read_en  = 1'b1;
    bus.write_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_in = 8'(8'h50 + i);
      @(negedge clk);
      chk("simh_data", bus.data_out, 8'h40 + i);
    end
    bus.write_en = 1'b0;
    for (int i = 4; i < 12; i++) begin
      @(negedge clk);
      chk("simh_drain", bus.data_out,
          (i < 8) ? 8'h40 + i : 8'h50 + i - 8);
    end
    bus.read_en = 1'b0;
    chk("simh_empty", bus.empty, 1);

    // timeout flush
    wr(8'h77, 1'b0);
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      chk("to_wait", bus.soft_reset, 0);
    end
    @(negedge clk);
    chk("to_srst", bus.soft_reset, 1);
    chk("to_empty", bus.empty, 1);
    chk("to_dout", bus.data_out, 0);
    bus.data_in  = 8'h99;
    bus.write_en = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0;
    chk("to_srst_low", bus.soft_reset, 0);
    chk("srst_wr_valid", bus.valid_out, 1);
    bus.read_en = 1'b1;
    @(negedge clk);
    bus.read_en = 1'b0;
    chk("srst_wr_data", bus.data_out, 8'h99);
    chk("srst_wr_empty", bus.empty, 1);

    // timeout restart by a read pulse at cycle 29
    wr(8'h01, 1'b0);
    wr(8'h02, 1'b0);
    repeat (28) begin
      @(negedge clk);
      chk("rs_wait", bus.soft_reset, 0);
    end
    bus.read_en = 1'b1;
    @(negedge clk);
    bus.read_en = 1'b0;
    chk("rs_pop", bus.data_out, 8'h01);
    chk("rs_noflush", bus.soft_reset, 0);
    chk("rs_valid", bus.valid_out, 1);
    repeat (29) begin
      @(negedge clk);
      chk("rs_wait2", bus.soft_reset, 0);
    end
    @(negedge clk);
    chk("rs_srst", bus.soft_reset, 1);
    chk("rs_empty", bus.empty, 1);

    // reset mid-packet with traffic
    wr(8'h8C, 1'b1);
    wr(8'h55, 1'b0);
    bus.read_en = 1'b1;
    @(negedge clk);
    bus.read_en = 1'b0;
    chk("pre_rst_pkt", bus.pkt_active, 1);
    chk("pre_rst_data", bus.data_out, 8'h8C);
    rst          = 1'b1;
    bus.data_in  = 8'hEE;
    bus.write_en = 1'b1;
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    bus.write_en = 1'b0;
    chk("rst2_empty", bus.empty, 1);
    chk("rst2_data", bus.data_out, 0);
    chk("rst2_pkt", bus.pkt_active, 0);
    chk("rst2_srst", bus.soft_reset, 0);
    chk("rst2_full", bus.full, 0);
    @(negedge clk);
    chk("rst2_hold", bus.valid_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
